// File: rtl/hangman_pkg.sv
// ============================================================================
// Module : hangman_pkg
// Brief  : Shared state encoding, default sizes, letter-code constants and
//          small arithmetic helpers for the Hangman round logic.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package hangman_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAYING = 2'd1,
        WON     = 2'd2,
        LOST    = 2'd3
    } state_t;

    localparam int          c_DEFAULT_NPOS      = 5;
    localparam int          c_DEFAULT_MAX_LIVES = 6;
    localparam int          c_LETTER_W          = 5;
    localparam logic [4:0]  c_DUMMY_CODE        = 5'b11111;

    function automatic logic [7:0] popcount(input logic [31:0] v);
        logic [7:0] n;
        n = 8'd0;
        for (int i = 0; i < 32; i++) begin
            n = n + {7'd0, v[i]};
        end
        return n;
    endfunction

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/life_counter.sv
// ============================================================================
// Module : life_counter
// Brief  : Loadable 4-bit down-counter with a last-life flag; never wraps.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module life_counter #(
    parameter logic [3:0] RESET_VALUE = 4'd6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       dec,
    input  logic [3:0] load_value,
    output logic [3:0] count,
    output logic       last
);

    logic [3:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= RESET_VALUE;
        end else if (load) begin
            r_count <= load_value;
        end else if (dec && (r_count != 4'd0)) begin
            r_count <= r_count - 4'd1;
        end
    end

    assign count = r_count;
    assign last  = (r_count == 4'd1);

endmodule

`default_nettype wire

// File: rtl/hangman_round_tracker.sv
// ============================================================================
// Module : hangman_round_tracker
// Brief  : Tracks revealed positions, lives and win/loss for one Hangman round.
//          Optional cumulative score enabled by defining HANGMAN_SCORE_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module hangman_round_tracker
    import hangman_pkg::*;
#(
    parameter int NPOS      = c_DEFAULT_NPOS,
    parameter int MAX_LIVES = c_DEFAULT_MAX_LIVES
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            new_game,
    input  logic [NPOS-1:0] word_mask,
    input  logic            guess_valid,
    input  logic [NPOS-1:0] hit,
    output logic [NPOS-1:0] revealed,
    output logic [3:0]      lives,
    output logic [1:0]      state,
`ifdef HANGMAN_SCORE_EN
    output logic [7:0]      score,
`endif
    output logic            won,
    output logic            lost,
    output logic            miss_pulse,
    output logic            dup_pulse
);

    localparam logic [3:0] c_MAX_LIVES = 4'(MAX_LIVES);

    state_t          r_state;
    logic [NPOS-1:0] r_mask;
    logic [NPOS-1:0] r_revealed;
    logic            r_won;
    logic            r_lost;
    logic            r_miss;
    logic            r_dup;

    logic [NPOS-1:0] w_eh;
    logic [NPOS-1:0] w_new_bits;
    logic [NPOS-1:0] w_next_rev;
    logic            w_accept;
    logic            w_miss;
    logic            w_dup;
    logic            w_reveal;
    logic            w_last;
    logic [3:0]      w_lives;

    // An empty mask wins immediately, so any guess arriving in that cycle is ignored.
    assign w_eh       = hit & r_mask;
    assign w_new_bits = w_eh & ~r_revealed;
    assign w_next_rev = r_revealed | w_eh;
    assign w_accept   = (r_state == PLAYING) && guess_valid && !new_game && (r_mask != '0);
    assign w_miss     = w_accept && (w_eh == '0);
    assign w_dup      = w_accept && (w_eh != '0) && (w_new_bits == '0);
    assign w_reveal   = w_accept && (w_new_bits != '0);

    life_counter #(
        .RESET_VALUE (c_MAX_LIVES)
    ) u_life_counter (
        .clk        (clk),
        .reset      (reset),
        .load       (new_game),
        .dec        (w_miss),
        .load_value (c_MAX_LIVES),
        .count      (w_lives),
        .last       (w_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_mask     <= '0;
            r_revealed <= '0;
            r_won      <= 1'b0;
            r_lost     <= 1'b0;
            r_miss     <= 1'b0;
            r_dup      <= 1'b0;
        end else if (new_game) begin
            r_state    <= PLAYING;
            r_mask     <= word_mask;
            r_revealed <= '0;
            r_won      <= 1'b0;
            r_lost     <= 1'b0;
            r_miss     <= 1'b0;
            r_dup      <= 1'b0;
        end else begin
            r_miss <= w_miss;
            r_dup  <= w_dup;
            if (r_state == PLAYING) begin
                if (r_mask == '0) begin
                    r_state <= WON;
                    r_won   <= 1'b1;
                end else if (w_miss && w_last) begin
                    r_state <= LOST;
                    r_lost  <= 1'b1;
                end else if (w_reveal) begin
                    r_revealed <= w_next_rev;
                    if (w_next_rev == r_mask) begin
                        r_state <= WON;
                        r_won   <= 1'b1;
                    end
                end
            end
        end
    end

`ifdef HANGMAN_SCORE_EN
    logic [7:0] r_score;
    logic [7:0] w_score_rev;
    logic       w_reach_won;

    assign w_reach_won = (r_state == PLAYING) && !new_game &&
                         ((r_mask == '0) || (w_reveal && (w_next_rev == r_mask)));
    assign w_score_rev = w_reveal ? sat_add8(r_score, popcount(32'(w_new_bits))) : r_score;

    // Score survives new_game so it accumulates across rounds.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_score <= 8'd0;
        end else if (w_reach_won) begin
            r_score <= sat_add8(w_score_rev, {4'd0, w_lives});
        end else begin
            r_score <= w_score_rev;
        end
    end

    assign score = r_score;
`endif

    assign revealed   = r_revealed;
    assign lives      = w_lives;
    assign state      = r_state;
    assign won        = r_won;
    assign lost       = r_lost;
    assign miss_pulse = r_miss;
    assign dup_pulse  = r_dup;

endmodule

`default_nettype wire

// File: tb/tb_hangman_round_tracker.sv
// ============================================================================
// Module : tb_hangman_round_tracker
// Brief  : Directed table-driven bench for hangman_round_tracker.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hangman_round_tracker;

    typedef struct {
        logic       ng;
        logic       gv;
        logic [4:0] hit;
        logic [4:0] wm;
        logic [4:0] rev;
        logic [3:0] lives;
        logic [1:0] st;
        logic       miss;
        logic       dup;
    } vec_t;

    localparam int c_NVEC = 27;

    logic       clk;
    logic       reset;
    logic       new_game;
    logic [4:0] word_mask;
    logic       guess_valid;
    logic [4:0] hit;
    logic [4:0] revealed;
    logic [3:0] lives;
    logic [1:0] state;
    logic       won;
    logic       lost;
    logic       miss_pulse;
    logic       dup_pulse;
`ifdef HANGMAN_SCORE_EN
    logic [7:0] score;
`endif

    int   errors = 0;
    int   checks = 0;
    vec_t vecs [c_NVEC];

    hangman_round_tracker #(
        .NPOS      (5),
        .MAX_LIVES (6)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .new_game    (new_game),
        .word_mask   (word_mask),
        .guess_valid (guess_valid),
        .hit         (hit),
        .revealed    (revealed),
        .lives       (lives),
        .state       (state),
`ifdef HANGMAN_SCORE_EN
        .score       (score),
`endif
        .won         (won),
        .lost        (lost),
        .miss_pulse  (miss_pulse),
        .dup_pulse   (dup_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] actual=%0h required=%0h", name, idx, act, exp);
        end
    endtask

    task automatic check_all(input int idx, input logic [4:0] e_rev, input logic [3:0] e_lives,
                             input logic [1:0] e_st, input logic e_miss, input logic e_dup);
        check("revealed", idx, {3'd0, revealed}, {3'd0, e_rev});
        check("lives",    idx, {4'd0, lives},    {4'd0, e_lives});
        check("state",    idx, {6'd0, state},    {6'd0, e_st});
        check("won",      idx, {7'd0, won},      {7'd0, e_st == 2'd2});
        check("lost",     idx, {7'd0, lost},     {7'd0, e_st == 2'd3});
        check("miss",     idx, {7'd0, miss_pulse}, {7'd0, e_miss});
        check("dup",      idx, {7'd0, dup_pulse},  {7'd0, e_dup});
    endtask

    task automatic drive(input logic r, input logic ng, input logic gv, input logic [4:0] h, input logic [4:0] wm);
        @(negedge clk);
        reset       = r;
        new_game    = ng;
        guess_valid = gv;
        hit         = h;
        word_mask   = wm;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            ng  gv  hit       wm        rev       lives st  miss dup
        vecs[0]  = '{1'b0,1'b1,5'b00001,5'b00000,5'b00000,4'd6,2'd0,1'b0,1'b0};
        vecs[1]  = '{1'b1,1'b0,5'b00000,5'b01111,5'b00000,4'd6,2'd1,1'b0,1'b0};
        vecs[2]  = '{1'b0,1'b1,5'b00001,5'b00000,5'b00001,4'd6,2'd1,1'b0,1'b0};
        vecs[3]  = '{1'b0,1'b1,5'b00010,5'b00000,5'b00011,4'd6,2'd1,1'b0,1'b0};
        vecs[4]  = '{1'b0,1'b1,5'b00100,5'b00000,5'b00111,4'd6,2'd1,1'b0,1'b0};
        vecs[5]  = '{1'b0,1'b1,5'b01000,5'b00000,5'b01111,4'd6,2'd2,1'b0,1'b0};
        vecs[6]  = '{1'b0,1'b1,5'b00000,5'b00000,5'b01111,4'd6,2'd2,1'b0,1'b0};
        vecs[7]  = '{1'b1,1'b0,5'b00000,5'b01111,5'b00000,4'd6,2'd1,1'b0,1'b0};
        vecs[8]  = '{1'b0,1'b1,5'b00000,5'b00000,5'b00000,4'd5,2'd1,1'b1,1'b0};
        vecs[9]  = '{1'b0,1'b1,5'b00000,5'b00000,5'b00000,4'd4,2'd1,1'b1,1'b0};
        vecs[10] = '{1'b0,1'b1,5'b00000,5'b00000,5'b00000,4'd3,2'd1,1'b1,1'b0};
        vecs[11] = '{1'b0,1'b1,5'b00000,5'b00000,5'b00000,4'd2,2'd1,1'b1,1'b0};
        vecs[12] = '{1'b0,1'b1,5'b00000,5'b00000,5'b00000,4'd1,2'd1,1'b1,1'b0};
        vecs[13] = '{1'b0,1'b1,5'b00000,5'b00000,5'b00000,4'd0,2'd3,1'b1,1'b0};
        vecs[14] = '{1'b0,1'b1,5'b00000,5'b00000,5'b00000,4'd0,2'd3,1'b0,1'b0};
        vecs[15] = '{1'b1,1'b0,5'b00000,5'b01111,5'b00000,4'd6,2'd1,1'b0,1'b0};
        vecs[16] = '{1'b0,1'b1,5'b10000,5'b00000,5'b00000,4'd5,2'd1,1'b1,1'b0};
        vecs[17] = '{1'b0,1'b1,5'b00001,5'b00000,5'b00001,4'd5,2'd1,1'b0,1'b0};
        vecs[18] = '{1'b0,1'b1,5'b00001,5'b00000,5'b00001,4'd5,2'd1,1'b0,1'b1};
        vecs[19] = '{1'b0,1'b0,5'b00000,5'b00000,5'b00001,4'd5,2'd1,1'b0,1'b0};
        vecs[20] = '{1'b1,1'b0,5'b00000,5'b01111,5'b00000,4'd6,2'd1,1'b0,1'b0};
        vecs[21] = '{1'b0,1'b1,5'b01001,5'b00000,5'b01001,4'd6,2'd1,1'b0,1'b0};
        vecs[22] = '{1'b1,1'b1,5'b00001,5'b01111,5'b00000,4'd6,2'd1,1'b0,1'b0};
        vecs[23] = '{1'b0,1'b1,5'b00110,5'b00000,5'b00110,4'd6,2'd1,1'b0,1'b0};
        vecs[24] = '{1'b0,1'b1,5'b01001,5'b00000,5'b01111,4'd6,2'd2,1'b0,1'b0};
        vecs[25] = '{1'b1,1'b0,5'b00000,5'b00000,5'b00000,4'd6,2'd1,1'b0,1'b0};
        vecs[26] = '{1'b0,1'b0,5'b00000,5'b00000,5'b00000,4'd6,2'd2,1'b0,1'b0};

        reset = 1'b1; new_game = 1'b0; guess_valid = 1'b0; hit = '0; word_mask = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all(100, 5'b00000, 4'd6, 2'd0, 1'b0, 1'b0);
`ifdef HANGMAN_SCORE_EN
        check("score_rst", 100, score, 8'd0);
`endif

        for (int i = 0; i < c_NVEC; i++) begin
            drive(1'b0, vecs[i].ng, vecs[i].gv, vecs[i].hit, vecs[i].wm);
            check_all(i, vecs[i].rev, vecs[i].lives, vecs[i].st, vecs[i].miss, vecs[i].dup);
        end

        // Reset in the middle of a round, with a guess pending on the same edge.
        drive(1'b0, 1'b1, 1'b0, 5'b00000, 5'b01111);
        drive(1'b0, 1'b0, 1'b1, 5'b00000, 5'b00000);
        check_all(200, 5'b00000, 4'd5, 2'd1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 5'b00001, 5'b00000);
        check_all(201, 5'b00000, 4'd6, 2'd0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 5'b00001, 5'b00000);
        check_all(202, 5'b00000, 4'd6, 2'd0, 1'b0, 1'b0);

`ifdef HANGMAN_SCORE_EN
        check("score_after_reset", 202, score, 8'd0);
        drive(1'b0, 1'b1, 1'b0, 5'b00000, 5'b01111);
        drive(1'b0, 1'b0, 1'b1, 5'b00000, 5'b00000);
        drive(1'b0, 1'b0, 1'b1, 5'b00001, 5'b00000);
        drive(1'b0, 1'b0, 1'b1, 5'b00010, 5'b00000);
        check("score_mid", 300, score, 8'd2);
        drive(1'b0, 1'b0, 1'b1, 5'b00100, 5'b00000);
        drive(1'b0, 1'b0, 1'b1, 5'b01000, 5'b00000);
        check("score_win", 301, score, 8'd9);
        check_all(301, 5'b01111, 4'd5, 2'd2, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 5'b00000, 5'b00001);
        check("score_keep", 302, score, 8'd9);
`endif

        drive(1'b0, 1'b0, 1'b0, 5'b00000, 5'b00000);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
